// File: rtl/ddr_io_pkg.sv
// Shared types and constants for the DDR output path sequencer.
package ddr_io_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAKE   = 3'd1,
    ST_ARM    = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_DRAIN  = 3'd4
  } seq_state_t;

  localparam logic [1:0] IDLE_PATTERN_DEF = 2'b00;
  localparam int         UNDERRUN_W       = 16;

  // Registered output bundle; one field per pad-side control.
  typedef struct packed {
    logic       ibuf_en;
    logic       oddr_rst;
    logic       oddr_en;
    logic       obuf_oe;
    logic       ready;
    logic [1:0] oddr_d;
    logic       done;
  } path_out_t;

  function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
    return (&v) ? v : v + UNDERRUN_W'(1);
  endfunction

endpackage

// File: rtl/io_seq_counter.sv
// Loadable down-counter with zero flag; times the settle and flush windows.
module io_seq_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/ddr_out_path_seq.sv
// Power-up / streaming / shutdown sequencer for the differential DDR output path.
module ddr_out_path_seq
  import ddr_io_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 4,
  parameter int         FLUSH_CYCLES  = 2,
  parameter logic [1:0] IDLE_PATTERN  = IDLE_PATTERN_DEF,
  parameter int         CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  tx_valid,
  input  logic [1:0]            tx_data,
  output logic                  tx_ready,
  output logic                  ibuf_en,
  output logic                  oddr_rst,
  output logic                  oddr_en,
  output logic [1:0]            oddr_d,
  output logic                  obuf_oe,
  output logic                  busy,
  output logic                  done,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FLUSH_LOAD  = CNT_W'(FLUSH_CYCLES - 1);

  localparam path_out_t OUT_IDLE = '{
    ibuf_en:  1'b0,
    oddr_rst: 1'b1,
    oddr_en:  1'b0,
    obuf_oe:  1'b0,
    ready:    1'b0,
    oddr_d:   IDLE_PATTERN,
    done:     1'b0
  };

  seq_state_t       state, state_nxt;
  path_out_t        out_q, out_nxt;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt;
  logic             accept;

  io_seq_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt),
    .zero     (cnt_zero)
  );

  // A word offered alongside stop is refused, so acceptance gates on stop directly.
  assign accept  = (state == ST_ACTIVE) && tx_valid && !stop;
  assign cnt_dec = (state == ST_WAKE) || (state == ST_DRAIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_val   = '0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_WAKE;
          cnt_load  = 1'b1;
          cnt_val   = SETTLE_LOAD;
        end
      end
      ST_WAKE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (cnt_zero) begin
          state_nxt = ST_ARM;
        end
      end
      ST_ARM: begin
        state_nxt = stop ? ST_IDLE : ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (stop) begin
          state_nxt = ST_DRAIN;
          cnt_load  = 1'b1;
          cnt_val   = FLUSH_LOAD;
        end
      end
      ST_DRAIN: begin
        if (cnt_zero) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    out_nxt = OUT_IDLE;
    unique case (state_nxt)
      ST_IDLE: out_nxt = OUT_IDLE;
      ST_WAKE: begin
        out_nxt.ibuf_en = 1'b1;
      end
      ST_ARM: begin
        out_nxt.ibuf_en  = 1'b1;
        out_nxt.oddr_rst = 1'b0;
        out_nxt.oddr_en  = 1'b1;
      end
      ST_ACTIVE: begin
        out_nxt.ibuf_en  = 1'b1;
        out_nxt.oddr_rst = 1'b0;
        out_nxt.oddr_en  = 1'b1;
        out_nxt.obuf_oe  = 1'b1;
        out_nxt.ready    = 1'b1;
        out_nxt.oddr_d   = accept ? tx_data : IDLE_PATTERN;
      end
      ST_DRAIN: begin
        out_nxt.ibuf_en  = 1'b1;
        out_nxt.oddr_rst = 1'b0;
        out_nxt.oddr_en  = 1'b1;
        out_nxt.obuf_oe  = 1'b1;
      end
      default: out_nxt = OUT_IDLE;
    endcase
    out_nxt.done = (state == ST_DRAIN) && (state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= OUT_IDLE;
    end else begin
      out_q <= out_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= '0;
    end else if ((state == ST_ACTIVE) && !tx_valid) begin
      underrun_cnt <= sat_inc(underrun_cnt);
    end
  end

  assign ibuf_en  = out_q.ibuf_en;
  assign oddr_rst = out_q.oddr_rst;
  assign oddr_en  = out_q.oddr_en;
  assign oddr_d   = out_q.oddr_d;
  assign obuf_oe  = out_q.obuf_oe;
  assign done     = out_q.done;
  assign tx_ready = out_q.ready && !stop;
  assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_ddr_out_path_seq.sv
// Directed bench for ddr_out_path_seq with a per-cycle ordering monitor.
module tb_ddr_out_path_seq;

  logic        clk = 1'b0;
  logic        rst, start, stop, tx_valid;
  logic [1:0]  tx_data;
  logic        tx_ready, ibuf_en, oddr_rst, oddr_en, obuf_oe, busy, done;
  logic [1:0]  oddr_d;
  logic [15:0] underrun_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_en   = 1'b0;

  ddr_out_path_seq #(
    .SETTLE_CYCLES (4),
    .FLUSH_CYCLES  (2),
    .IDLE_PATTERN  (2'b00),
    .CNT_W         (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .ibuf_en      (ibuf_en),
    .oddr_rst     (oddr_rst),
    .oddr_en      (oddr_en),
    .oddr_d       (oddr_d),
    .obuf_oe      (obuf_oe),
    .busy         (busy),
    .done         (done),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("inv_oe_rst", 32'(!(obuf_oe && oddr_rst)), 32'd1);
      check("inv_en_ibuf", 32'(!(oddr_en && !ibuf_en)), 32'd1);
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; tx_valid = 1'b0; tx_data = 2'b00;
    tick(); tick();
    check("rst_ibuf", 32'(ibuf_en), 32'd0);
    check("rst_oddr_rst", 32'(oddr_rst), 32'd1);
    check("rst_oddr_en", 32'(oddr_en), 32'd0);
    check("rst_oddr_d", 32'(oddr_d), 32'd0);
    check("rst_oe", 32'(obuf_oe), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_underrun", 32'(underrun_cnt), 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Bring-up: start sampled at cycle 0, walk cycles 1..6.
    start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      start = 1'b0;
      check($sformatf("up_ibuf_c%0d", i), 32'(ibuf_en), 32'd1);
      check($sformatf("up_oddr_rst_c%0d", i), 32'(oddr_rst), 32'(i < 5));
      check($sformatf("up_oddr_en_c%0d", i), 32'(oddr_en), 32'(i >= 5));
      check($sformatf("up_ready_c%0d", i), 32'(tx_ready), 32'(i >= 6));
      check($sformatf("up_oe_c%0d", i), 32'(obuf_oe), 32'(i >= 6));
    end

    // Streaming 01, 10, 11.
    tx_valid = 1'b1;
    tx_data = 2'b01; tick(); check("stream_01", 32'(oddr_d), 32'h1);
    tx_data = 2'b10; tick(); check("stream_10", 32'(oddr_d), 32'h2);
    tx_data = 2'b11; tick(); check("stream_11", 32'(oddr_d), 32'h3);
    tx_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("underrun_d_%0d", i), 32'(oddr_d), 32'h0);
    end
    check("underrun_3", 32'(underrun_cnt), 32'd3);
    check("ready_hold", 32'(tx_ready), 32'd1);

    // Saturation: idle ACTIVE until the counter reaches FFFE, FFFF, then holds.
    repeat (65531) tick();
    check("underrun_fffe", 32'(underrun_cnt), 32'hFFFE);
    tick();
    check("underrun_ffff", 32'(underrun_cnt), 32'hFFFF);
    repeat (3) tick();
    check("underrun_sat", 32'(underrun_cnt), 32'hFFFF);

    // Shutdown with a word offered in the stop cycle.
    stop = 1'b1; tx_valid = 1'b1; tx_data = 2'b11;
    #1;
    check("stop_ready_comb", 32'(tx_ready), 32'd0);
    tick();
    stop = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      check($sformatf("drain_d_%0d", i), 32'(oddr_d), 32'h0);
      check($sformatf("drain_ready_%0d", i), 32'(tx_ready), 32'd0);
      check($sformatf("drain_oe_%0d", i), 32'(obuf_oe), 32'd1);
      check($sformatf("drain_done_%0d", i), 32'(done), 32'd0);
      tick();
    end
    check("off_oe", 32'(obuf_oe), 32'd0);
    check("off_done", 32'(done), 32'd1);
    check("off_busy", 32'(busy), 32'd0);
    tx_valid = 1'b0;
    tick();
    check("off_done_pulse", 32'(done), 32'd0);

    // Abort at the second WAKE cycle.
    start = 1'b1; tick(); start = 1'b0;
    check("abort_wake1_rst", 32'(oddr_rst), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("abort_wake2_rst", 32'(oddr_rst), 32'd1);
    tick();
    check("abort_ibuf", 32'(ibuf_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_oddr_rst", 32'(oddr_rst), 32'd1);
    check("abort_underrun_kept", 32'(underrun_cnt), 32'hFFFF);
    tick();
    check("abort_done_later", 32'(done), 32'd0);

    // Random start/stop/rst; the monitor checks ordering each cycle.
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(0, 39) == 0);
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 11) == 0);
      tx_valid = $urandom_range(0, 1);
      tx_data  = 2'($urandom_range(0, 3));
      tick();
    end
    start = 1'b0; stop = 1'b0; tx_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;

    // start+stop together in IDLE: start wins.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 32'd1);
    check("startstop_ibuf", 32'(ibuf_en), 32'd1);
    repeat (5) tick();
    check("reup_ready", 32'(tx_ready), 32'd1);
    repeat (2) tick();
    check("reup_underrun", 32'(underrun_cnt), 32'd2);

    // Reset mid-ACTIVE.
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_ibuf", 32'(ibuf_en), 32'd0);
    check("midrst_oddr_rst", 32'(oddr_rst), 32'd1);
    check("midrst_oe", 32'(obuf_oe), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_underrun", 32'(underrun_cnt), 32'd0);
    tick();
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
